// File: rtl/bip_data_memory_pkg.sv
// Shared widths, I/O window offsets and bus-error bit positions for the BIP I data memory.
package bip_mem_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;

   localparam logic [3:0] IO_PORTOUT = 4'd0;
   localparam logic [3:0] IO_PORTIN  = 4'd1;
   localparam logic [3:0] IO_TCOUNT  = 4'd2;
   localparam logic [3:0] IO_TCMP    = 4'd3;
   localparam logic [3:0] IO_TSTAT   = 4'd4;
   localparam logic [3:0] IO_BUSERR  = 4'd5;
   localparam logic [3:0] IO_RDCNT   = 4'd6;
   localparam logic [3:0] IO_WRCNT   = 4'd7;

   localparam int BE_COLLIDE  = 0;
   localparam int BE_UNMAPPED = 1;
endpackage

// File: rtl/bip_data_memory_if.sv
// CPU data-side bus: the CPU (master) drives address/strobes/write data, the memory (slave) returns read data.
interface bip_data_memory_if;
   import bip_mem_pkg::*;

   logic [ADDR_W-1:0] DataAddr;
   logic              Rd;
   logic              Wr;
   logic [DATA_W-1:0] In_Data;
   logic [DATA_W-1:0] Out_Data;

   modport master (output DataAddr, Rd, Wr, In_Data, input Out_Data);
   modport slave  (input DataAddr, Rd, Wr, In_Data, output Out_Data);
endinterface

// File: rtl/bip_data_memory_io_timer.sv
// Prescaled 16-bit timer with compare register and sticky compare flag.
module bip_io_timer
   import bip_mem_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              load_cnt,
   input  logic              load_cmp,
   input  logic              clr_flag,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] tcount,
   output logic [DATA_W-1:0] tcmp,
   output logic              flag
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0]     presc;
   logic              wrap;
   logic [DATA_W-1:0] cnt_inc;

   assign wrap    = (presc == PMAX);
   assign cnt_inc = tcount + 1'b1;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         presc  <= '0;
         tcount <= '0;
         tcmp   <= '0;
         flag   <= 1'b0;
      end else begin
         if (load_cnt) begin
            presc  <= '0;
            tcount <= wdata;
         end else if (wrap) begin
            presc  <= '0;
            tcount <= cnt_inc;
         end else begin
            presc  <= presc + 1'b1;
         end
         if (load_cmp)
            tcmp <= wdata;
         // Only an increment can raise the flag; a load never does, and a set wins over a clear.
         if (!load_cnt && wrap && (cnt_inc == tcmp))
            flag <= 1'b1;
         else if (clr_flag)
            flag <= 1'b0;
      end
   end
endmodule

// File: rtl/bip_data_memory.sv
// BIP I data-side responder: data RAM plus a 16-word I/O window (ports, timer, bus-error status).
// Define ACCESS_STATS_EN to add the saturating Rd/Wr cycle counters at I/O offsets 6 and 7.
module bip_data_memory
   import bip_mem_pkg::*;
#(
   parameter int                DEPTH    = 2040,
   parameter logic [ADDR_W-1:0] IO_BASE  = 11'h7F0,
   parameter int                PRESCALE = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   bip_data_memory_if.slave   bus,
   input  logic [DATA_W-1:0]  PortIn,
   output logic [DATA_W-1:0]  PortOut,
   output logic               TimerIrq
);
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [RAM_AW-1:0] ram_idx;
   logic [ADDR_W-1:0] io_rel;
   logic [3:0]        io_off;
   logic              io_hit, io_mapped, ram_hit, unmapped;
   logic              ram_we, io_we;
   logic              we_portout, we_tcount, we_tcmp, we_tstat, we_buserr;
   logic [DATA_W-1:0] portout_q, portin_q, tcount, tcmp, rdata;
   logic              flag;
   logic [1:0]        buserr, be_set, be_clr;

   assign io_rel  = bus.DataAddr - IO_BASE;
   assign io_off  = io_rel[3:0];
   assign io_hit  = (bus.DataAddr >= IO_BASE) && (io_rel[ADDR_W-1:4] == '0);
   // The I/O window always wins, so a DEPTH reaching past IO_BASE simply loses those words.
   assign ram_hit = (int'(bus.DataAddr) < DEPTH) && (bus.DataAddr < IO_BASE);
   assign ram_idx = RAM_AW'(bus.DataAddr);

   always_comb begin
      io_mapped = 1'b0;
      if (io_hit) begin
         case (io_off)
            IO_PORTOUT, IO_PORTIN, IO_TCOUNT,
            IO_TCMP, IO_TSTAT, IO_BUSERR: io_mapped = 1'b1;
`ifdef ACCESS_STATS_EN
            IO_RDCNT, IO_WRCNT:           io_mapped = 1'b1;
`endif
            default:                      io_mapped = 1'b0;
         endcase
      end
   end

   assign unmapped   = !ram_hit && !io_mapped;
   assign ram_we     = bus.Wr && ram_hit && !Reset;
   assign io_we      = bus.Wr && io_mapped;
   assign we_portout = io_we && (io_off == IO_PORTOUT);
   assign we_tcount  = io_we && (io_off == IO_TCOUNT);
   assign we_tcmp    = io_we && (io_off == IO_TCMP);
   assign we_tstat   = io_we && (io_off == IO_TSTAT);
   assign we_buserr  = io_we && (io_off == IO_BUSERR);

   assign be_set[BE_COLLIDE]  = bus.Rd && bus.Wr;
   assign be_set[BE_UNMAPPED] = unmapped && (bus.Rd || bus.Wr);
   assign be_clr              = we_buserr ? bus.In_Data[1:0] : 2'b00;

   // RAM: no reset on contents; a same-address read sees the old word.
   always_ff @(posedge Clock) begin
      if (ram_we)
         mem[ram_idx] <= bus.In_Data;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         portout_q <= '0;
         portin_q  <= '0;
         buserr    <= '0;
      end else begin
         portin_q <= PortIn;
         if (we_portout)
            portout_q <= bus.In_Data;
         buserr <= be_set | (buserr & ~be_clr);
      end
   end

   bip_io_timer #(.PRESCALE(PRESCALE)) u_timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .load_cnt (we_tcount),
      .load_cmp (we_tcmp),
      .clr_flag (we_tstat && bus.In_Data[0]),
      .wdata    (bus.In_Data),
      .tcount   (tcount),
      .tcmp     (tcmp),
      .flag     (flag)
   );

`ifdef ACCESS_STATS_EN
   logic [DATA_W-1:0] rdcnt, wrcnt;

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A write to a counter clears it even though that write is itself a counted cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rdcnt <= '0;
         wrcnt <= '0;
      end else begin
         if (io_we && (io_off == IO_RDCNT))
            rdcnt <= '0;
         else if (bus.Rd)
            rdcnt <= sat_inc(rdcnt);
         if (io_we && (io_off == IO_WRCNT))
            wrcnt <= '0;
         else if (bus.Wr)
            wrcnt <= sat_inc(wrcnt);
      end
   end
`endif

   always_comb begin
      rdata = '0;
      if (bus.Rd) begin
         if (ram_hit) begin
            rdata = mem[ram_idx];
         end else if (io_hit) begin
            case (io_off)
               IO_PORTOUT: rdata = portout_q;
               IO_PORTIN:  rdata = portin_q;
               IO_TCOUNT:  rdata = tcount;
               IO_TCMP:    rdata = tcmp;
               IO_TSTAT:   rdata = DATA_W'(flag);
               IO_BUSERR:  rdata = DATA_W'(buserr);
`ifdef ACCESS_STATS_EN
               IO_RDCNT:   rdata = rdcnt;
               IO_WRCNT:   rdata = wrcnt;
`endif
               default:    rdata = '0;
            endcase
         end
      end
   end

   assign bus.Out_Data = rdata;
   assign PortOut      = portout_q;
   assign TimerIrq     = flag;
endmodule
